// File: rtl/dual_port_ram.sv
// dual_port_ram -- simple dual-port synchronous RAM.
//
// It has one write port and one read port, both on clk. Read data is
// registered, so it appears one cycle after the read address.
//
// When a read and a write hit the same address on the same edge, the read
// returns the old contents (read-before-write). There is no bypass path.
//
// Ports:
//   clk     in   system clock; all state updates on the rising edge
//   rstN    in   asynchronous active-low reset; clears q, blocks writes
//   we      in   write enable
//   dataIn  in   write data             [DATA_WIDTH-1:0]
//   wAddr   in   write address          [ADDR_WIDTH-1:0]
//   rAddr   in   read address           [ADDR_WIDTH-1:0]
//   q       out  registered read data   [DATA_WIDTH-1:0]
module dual_port_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic [ADDR_WIDTH-1:0] wAddr,
  input  logic [ADDR_WIDTH-1:0] rAddr,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];

  // The array is left out of reset so it still maps onto block RAM.
  // rstN only gates the write enable, so writes are ignored during reset.
  always_ff @(posedge clk) begin
    if (we && rstN) begin
      mem[wAddr] <= dataIn;
    end
  end

  // The read samples the array before this edge's write lands, which gives
  // read-before-write behaviour on a same-address collision.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      q <= '0;
    end else begin
      q <= mem[rAddr];
    end
  end

endmodule

// File: tb/tb_dual_port_ram.sv
module tb_dual_port_ram;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk    = 1'b0;
  logic          rstN   = 1'b1;
  logic          we     = 1'b0;
  logic [DW-1:0] dataIn = '0;
  logic [AW-1:0] wAddr  = '0;
  logic [AW-1:0] rAddr  = '0;
  logic [DW-1:0] q;

  always #5 clk = ~clk;

  dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rstN   (rstN),
    .we     (we),
    .dataIn (dataIn),
    .wAddr  (wAddr),
    .rAddr  (rAddr),
    .q      (q)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: a plain array of words, plus a flag per word that
  // records whether it has been written yet.
  logic [DW-1:0] model [DEPTH];
  bit            valid [DEPTH];
  logic [DW-1:0] expQ;
  bit            expValid;

  logic [DW-1:0] fillVals [10] = '{
    32'hdeadbeef, 32'h8badf00d, 32'h00c0ffee, 32'hdeadc0de, 32'hbadf000d,
    32'hdefac8ed, 32'hcafebabe, 32'hdeadd00d, 32'hcafed00d, 32'hdeadbabe
  };

  // One clock cycle of normal operation. The expected q is the word that
  // was stored before this edge; the model takes the write after the edge.
  task automatic step(input bit w, input logic [AW-1:0] wa,
                      input logic [AW-1:0] ra, input logic [DW-1:0] d);
    we = w; wAddr = wa; rAddr = ra; dataIn = d;
    expQ = model[ra];
    expValid = valid[ra];
    @(posedge clk);
    if (w) begin
      model[wa] = d;
      valid[wa] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    #1 rstN = 1'b0;
    #1;
    checks++;
    if (q !== 32'h0) $display("FAIL reset_initial: q=%h expected=%h", q, 32'h0);
    else passed++;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 10; i++) step(1'b1, AW'(i), '0, fillVals[i]);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, AW'(i), 32'h0);
      checks++;
      if (q !== fillVals[i]) $display("FAIL fill_read[%0d]: q=%h expected=%h", i, q, fillVals[i]);
      else passed++;
    end
  endtask

  task automatic test_write_disable();
    step(1'b0, 5'd3, 5'd3, 32'h12345678);
    step(1'b0, 5'd0, 5'd3, 32'h0);
    checks++;
    if (q !== 32'hdeadc0de) $display("FAIL write_disable: q=%h expected=%h", q, 32'hdeadc0de);
    else passed++;
  endtask

  task automatic test_collision();
    step(1'b1, 5'd5, 5'd5, 32'h0badcafe);
    checks++;
    if (q !== 32'hdefac8ed) $display("FAIL collision_old: q=%h expected=%h", q, 32'hdefac8ed);
    else passed++;
    step(1'b0, 5'd0, 5'd5, 32'h0);
    checks++;
    if (q !== 32'h0badcafe) $display("FAIL collision_new: q=%h expected=%h", q, 32'h0badcafe);
    else passed++;
  endtask

  task automatic test_independent();
    step(1'b1, 5'd31, 5'd0, 32'h11111111);
    checks++;
    if (q !== 32'hdeadbeef) $display("FAIL independent_read: q=%h expected=%h", q, 32'hdeadbeef);
    else passed++;
    step(1'b0, 5'd0, 5'd31, 32'h0);
    checks++;
    if (q !== 32'h11111111) $display("FAIL top_address: q=%h expected=%h", q, 32'h11111111);
    else passed++;
  endtask

  task automatic test_async_reset();
    step(1'b0, 5'd0, 5'd0, 32'h0);
    checks++;
    if (q !== 32'hdeadbeef) $display("FAIL pre_reset: q=%h expected=%h", q, 32'hdeadbeef);
    else passed++;
    // Assert reset mid-cycle; q must clear before the next rising edge.
    #3 rstN = 1'b0;
    #1;
    checks++;
    if (q !== 32'h0) $display("FAIL async_reset: q=%h expected=%h", q, 32'h0);
    else passed++;
    // A write attempted during reset must be dropped, and q must stay 0.
    we = 1'b1; wAddr = 5'd0; dataIn = 32'hffffffff; rAddr = 5'd0;
    @(posedge clk);
    #1;
    checks++;
    if (q !== 32'h0) $display("FAIL reset_hold: q=%h expected=%h", q, 32'h0);
    else passed++;
    @(negedge clk);
    we = 1'b0;
    rstN = 1'b1;
    step(1'b0, 5'd0, 5'd0, 32'h0);
    checks++;
    if (q !== 32'hdeadbeef) $display("FAIL reset_write_ignored: q=%h expected=%h", q, 32'hdeadbeef);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), AW'($urandom), AW'($urandom), DW'($urandom));
      if (expValid) begin
        checks++;
        if (q !== expQ) $display("FAIL random[%0d]: q=%h expected=%h", i, q, expQ);
        else passed++;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, AW'(i), 32'h0);
      if (expValid) begin
        checks++;
        if (q !== expQ) $display("FAIL sweep[%0d]: q=%h expected=%h", i, q, expQ);
        else passed++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = '0;
      valid[i] = 1'b0;
    end
    test_reset();
    test_fill();
    test_write_disable();
    test_collision();
    test_independent();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dual_port_ram.md
Name: dual_port_ram

Overview:
- Simple dual-port synchronous RAM: one write port and one independent read port, both on a single clock.
- Used as generic storage, e.g. register file or small buffers, inside the core.
- Depth is 2^ADDR_WIDTH words of DATA_WIDTH bits.
- Read data is registered, giving one cycle of latency.

Parameters:
- DATA_WIDTH, default 32: word width in bits.
- ADDR_WIDTH, default 5: address width in bits; depth = 2^ADDR_WIDTH (32 words by default).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rstN  input  1  asynchronous, active-low reset.
- we  input  1  write enable.
- dataIn  input  DATA_WIDTH  write data.
- wAddr  input  ADDR_WIDTH  write address.
- rAddr  input  ADDR_WIDTH  read address.
- q  output  DATA_WIDTH  registered read data.

Interface constraints (already decided):
- One clock; reset is asynchronous and active-low.
- Clock port is clk; reset port is rstN.

Behaviour:
- Storage: array mem[0 .. 2^ADDR_WIDTH-1] of DATA_WIDTH bits.
  - Memory contents are not cleared by reset, so the array stays inferable as block RAM.
  - Contents are undefined (X in simulation) until written.
- Write: on rising clk, if we==1 then mem[wAddr] <= dataIn.
  - If we==0, memory is unchanged.
  - Inputs are sampled at the edge. Data is visible to the read port from the next edge onward.
- Read: on rising clk, q <= mem[rAddr], every cycle regardless of we.
  - Latency is 1 cycle: an rAddr presented before edge N appears on q after edge N and holds until edge N+1.
- Reset: rstN low forces q to 0 immediately, without waiting for clk.
  - q stays 0 while rstN is low; writes are ignored while rstN is low.
  - Normal operation resumes on the first rising clk after rstN is released.
- Same-address collision (we=1, wAddr==rAddr, same edge): read-before-write.
  - q gets the old contents of that address.
  - The new data is returned on the following read.
- No bypass or forwarding path.
- Address wrap: addresses are exactly ADDR_WIDTH bits, so there is no out-of-range case.
- Read and write ports are fully independent. Different addresses in the same cycle never interfere.
- No handshakes, no stall, no error outputs.

Decomposition:
- No shared package is needed; widths are local parameters only.
- Single flat module with no sub-modules.
- The memory array plus the q register is the entire design.

Test Plan:
- Reset: pulse rstN low mid-cycle with q previously 32'hdeadbeef -> q becomes 0 immediately (asynchronously), before the next clk edge.
- Sequential fill and readback: write 32'hdeadbeef, 8badf00d, 00c0ffee, deadc0de, badf000d, defac8ed, cafebabe, deadd00d, cafed00d, deadbabe to addresses 0–9 with we=1. Then set we=0 and read 0–9 -> q equals each value one cycle after its rAddr, 10/10 match.
- Write-disable: with mem[3]=32'hdeadc0de, drive we=0, wAddr=3, dataIn=32'h12345678 -> reading address 3 still returns 32'hdeadc0de.
- Collision: mem[5]=32'hdefac8ed; same edge we=1, wAddr=rAddr=5, dataIn=32'h0badcafe -> q=32'hdefac8ed after that edge. Next cycle with rAddr=5 -> q=32'h0badcafe.
- Simultaneous independent ports: write 32'h11111111 to address 31 while reading address 0 (holding 32'hdeadbeef) -> q=32'hdeadbeef. A later read of address 31 -> 32'h11111111 (also checks the top address boundary).
